regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Bus-cycle sequencer that sits directly upstream of the 32 x 16-bit register file and is its only master. It accepts one register-file command at a time from the control unit: fetch one or two operands, full write, upper-byte write, increment or decrement. It expands each command into exact single-cycle read/write strobes on the register file's shared port. Fetched operands are latched into `opa`/`opb` for the ALU, and completion is signalled with a one-cycle `done` pulse.

## Interface
- No parameters; data width 16 and register id width 6 are fixed by the register file.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  command request; sampled only when `busy`=0.
- `cmd`  in  3  000 FETCH1, 001 FETCH2, 010 WRITE, 011 WRITEU, 100 INC, 101 DEC, 110/111 illegal.
- `rs`  in  6  source id for `opa`.
- `rt`  in  6  source id for `opb` (FETCH2 only).
- `rd`  in  6  destination id (WRITE/WRITEU/INC/DEC).
- `wdata`  in  16  write data (WRITE: full word; WRITEU: bits 7:0 go to the register's upper byte).
- `rf_dout`  in  16  register-file read data (tristate bus, valid only while `rf_read`=1).
- `rf_read`, `rf_write`, `rf_writeu`, `rf_inc`, `rf_dec`  out  1 each  register-file strobes.
- `rf_id`  out  6  register-file id.
- `rf_din`  out  16  register-file write data.
- `opa`, `opb`  out  16  latched operands.
- `busy`  out  1  high while a command is executing.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  high together with `done` when the completed command was illegal.

## Operation
- States: IDLE, RD_A, RD_B, WR, FIN.
- `busy` = state in {RD_A, RD_B, WR}. `start` is accepted in IDLE and FIN.
- On an accepted `start`, capture `cmd`, `rs`, `rt`, `rd` and `wdata` into internal registers. Later input changes have no effect on the running command.
- Next state after an accepted start:
  - FETCH1/FETCH2 → RD_A.
  - WRITE/WRITEU/INC/DEC → WR.
  - Illegal → FIN with `err`=1.
- RD_A: `rf_read`=1, `rf_id`=captured rs. At the edge, `opa`<=`rf_dout`. Next state is RD_B for FETCH2, otherwise FIN.
- RD_B: `rf_read`=1, `rf_id`=captured rt. At the edge, `opb`<=`rf_dout`. Next state FIN.
- WR: exactly one strobe high for exactly one cycle: `rf_write`, `rf_writeu`, `rf_inc` or `rf_dec` per captured cmd. `rf_id`=captured rd; `rf_din`=captured wdata (WRITE/WRITEU), 0 otherwise. Next state FIN.
- FIN: `done`=1 and `err` per the command. Without `start`, go to IDLE; with `start`, behave as IDLE (back-to-back).
- Strobe rules:
  - At most one of the five strobes is high in any cycle.
  - All strobes are 0 in IDLE and FIN.
  - `rf_read`=0 whenever no read is in progress, so the register-file bus is released.
  - `rf_id` and `rf_din` are 0 whenever no strobe is high.
- `opa`/`opb` hold their values until overwritten by a later fetch. FETCH1 leaves `opb` unchanged.
- Arithmetic: none in this block. INC/DEC wrap-around (FFFF→0000, 0000→FFFF) is performed by the register file; the sequencer only strobes.
- The high bit of the ids passes through unchanged. Ids are not range-checked here.

## Timing
- Reset: while `rst_n`=0, all five strobes are forced to 0 combinationally in that same cycle, so the register file cannot be modified during a reset cycle even mid-command.
- At the reset edge: state=IDLE; `opa`=`opb`=0; `done`=`err`=`busy`=0; `rf_id`=0; `rf_din`=0.
- A command interrupted by reset is abandoned: no `done` pulse, and any strobe not yet completed is never issued.
- Latency, from the edge sampling `start` to the cycle with `done`=1:
  - FETCH2: 3 cycles (RD_A, RD_B, FIN).
  - FETCH1, WRITE, WRITEU, INC, DEC: 2 cycles.
  - Illegal: 1 cycle.
- `opa`/`opb` are valid in the FIN cycle.
- Throughput: a new command can start at the FIN edge. FETCH2 sustains one command every 3 cycles; single-access commands one every 2 cycles.
- `start` while `busy`=1 is ignored and not queued.
- Read-after-write: a FETCH issued in the FIN cycle of a write to the same id returns the new value, because the write completed at the edge that ended WR.

## Test plan
- Reset: assert `rst_n`=0 for 2 cycles during the RD_B state of a FETCH2 → strobes 0 in the same cycle; after release `opa`=`opb`=0, `done`=0, no stale `done`.
- WRITE rd=5 `wdata`=16'hA5A5, then back-to-back FETCH2 rs=5 rt=5 started in the FIN cycle → `done` 3 cycles after the second start, `opa`=`opb`=16'hA5A5, only one strobe high per cycle.
- WRITE rd=3 16'h1234, then WRITEU rd=3 `wdata`=16'h00C3, then FETCH1 rs=3 → `opa`=16'hC334, `opb` unchanged.
- WRITE rd=7 16'hFFFF, INC rd=7, FETCH1 → 16'h0000; DEC rd=7, FETCH1 → 16'hFFFF. Each INC/DEC strobe is exactly 1 cycle wide.
- `start` pulsed in every cycle while `busy`=1 → ignored; `opa`/`opb` reflect only the accepted commands' ids.
- `cmd`=3'b110 → `done`=`err`=1 in the next cycle, zero strobes asserted, `opa`/`opb` unchanged.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Command sequencer and sole master of the 32 x 16 register file: expands one
// control-unit command into single-cycle read/write strobes and latches operands.
module regfile_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic [5:0]  rs,
  input  logic [5:0]  rt,
  input  logic [5:0]  rd,
  input  logic [15:0] wdata,
  input  logic [15:0] rf_dout,
  output logic        rf_read,
  output logic        rf_write,
  output logic        rf_writeu,
  output logic        rf_inc,
  output logic        rf_dec,
  output logic [5:0]  rf_id,
  output logic [15:0] rf_din,
  output logic [15:0] opa,
  output logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [2:0] C_FETCH1 = 3'b000;
  localparam logic [2:0] C_FETCH2 = 3'b001;
  localparam logic [2:0] C_WRITE  = 3'b010;
  localparam logic [2:0] C_WRITEU = 3'b011;
  localparam logic [2:0] C_INC    = 3'b100;
  localparam logic [2:0] C_DEC    = 3'b101;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic [15:0] wdata;
  } req_t;

  logic [2:0] state, state_nx;
  req_t       req_q;
  logic       err_q;
  logic       accept;

  function automatic logic is_illegal(input logic [2:0] c);
    return c[2] & c[1];
  endfunction

  function automatic logic [2:0] first_state(input logic [2:0] c);
    logic [2:0] s;
    s = S_FIN;
    case (c)
      C_FETCH1, C_FETCH2:             s = S_RD_A;
      C_WRITE, C_WRITEU, C_INC, C_DEC: s = S_WR;
      default:                        s = S_FIN;
    endcase
    return s;
  endfunction

  // FIN doubles as an idle slot so commands can run back-to-back.
  assign accept = start && ((state == S_IDLE) || (state == S_FIN));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = start ? first_state(cmd) : S_IDLE;
      S_RD_A:  state_nx = (req_q.cmd == C_FETCH2) ? S_RD_B : S_FIN;
      S_RD_B:  state_nx = S_FIN;
      S_WR:    state_nx = S_FIN;
      S_FIN:   state_nx = start ? first_state(cmd) : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req_q <= '0;
      err_q <= 1'b0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= '{cmd: cmd, rs: rs, rt: rt, rd: rd, wdata: wdata};
        err_q <= is_illegal(cmd);
      end
      if (state == S_RD_A) opa <= rf_dout;
      if (state == S_RD_B) opb <= rf_dout;
    end
  end

  // Strobes are gated by rst_n combinationally so a reset cycle can never
  // modify the register file, even in the middle of a command.
  always_comb begin
    rf_read   = 1'b0;
    rf_write  = 1'b0;
    rf_writeu = 1'b0;
    rf_inc    = 1'b0;
    rf_dec    = 1'b0;
    rf_id     = '0;
    rf_din    = '0;
    if (rst_n) begin
      case (state)
        S_RD_A: begin
          rf_read = 1'b1;
          rf_id   = req_q.rs;
        end
        S_RD_B: begin
          rf_read = 1'b1;
          rf_id   = req_q.rt;
        end
        S_WR: begin
          case (req_q.cmd)
            C_WRITE: begin
              rf_write = 1'b1;
              rf_id    = req_q.rd;
              rf_din   = req_q.wdata;
            end
            C_WRITEU: begin
              rf_writeu = 1'b1;
              rf_id     = req_q.rd;
              rf_din    = req_q.wdata;
            end
            C_INC: begin
              rf_inc = 1'b1;
              rf_id  = req_q.rd;
            end
            C_DEC: begin
              rf_dec = 1'b1;
              rf_id  = req_q.rd;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RD_A) || (state == S_RD_B) || (state == S_WR);
  assign done = (state == S_FIN);
  assign err  = done && err_q;

  a_strobe_onehot: assert property (@(posedge clk)
    $onehot0({rf_read, rf_write, rf_writeu, rf_inc, rf_dec}));
  a_wr_single: assert property (@(posedge clk) disable iff (!rst_n)
    (rf_write | rf_writeu | rf_inc | rf_dec) |=> !(rf_write | rf_writeu | rf_inc | rf_dec));

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: register-file model, scoreboard queue
// of expected completions, and a monitor that checks every done pulse and strobe.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cmd = '0;
  logic [5:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rf_dout;
  logic        rf_read, rf_write, rf_writeu, rf_inc, rf_dec;
  logic [5:0]  rf_id;
  logic [15:0] rf_din, opa, opb;
  logic        busy, done, err;

  regfile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .rs(rs), .rt(rt), .rd(rd),
    .wdata(wdata), .rf_dout(rf_dout), .rf_read(rf_read), .rf_write(rf_write),
    .rf_writeu(rf_writeu), .rf_inc(rf_inc), .rf_dec(rf_dec), .rf_id(rf_id),
    .rf_din(rf_din), .opa(opa), .opb(opb), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] opa;
    logic [15:0] opb;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  logic [15:0] mem [64];
  logic        prev_w = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: updates at the edge ending the strobe cycle, wraps on INC/DEC.
  initial for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  always @(posedge clk) begin
    if (rf_write)  mem[rf_id] <= rf_din;
    if (rf_writeu) mem[rf_id][15:8] <= rf_din[7:0];
    if (rf_inc)    mem[rf_id] <= mem[rf_id] + 16'd1;
    if (rf_dec)    mem[rf_id] <= mem[rf_id] - 16'd1;
  end
  assign rf_dout = rf_read ? mem[rf_id] : 16'hDEAD;

  // Monitor: pops on every done pulse, checks strobe hygiene each cycle.
  always @(negedge clk) begin
    int   ns;
    exp_t e;
    ns = $countones({rf_read, rf_write, rf_writeu, rf_inc, rf_dec});
    if (ns > 1) begin
      nerr++; $display("FAIL strobe_onehot: %0d strobes high at cycle %0d, required <=1", ns, cyc);
    end
    if (ns == 0 && (rf_id != 0 || rf_din != 0)) begin
      nerr++; $display("FAIL idle_bus: rf_id=%h rf_din=%h with no strobe, required 0", rf_id, rf_din);
    end
    if ((rf_inc | rf_dec) && rf_din != 0) begin
      nerr++; $display("FAIL incdec_din: rf_din=%h, required 0", rf_din);
    end
    if (done && ns != 0) begin
      nerr++; $display("FAIL fin_strobe: %0d strobes during done, required 0", ns);
    end
    if ((rf_write | rf_writeu | rf_inc | rf_dec) && prev_w) begin
      nerr++; $display("FAIL strobe_width: write strobe high 2 cycles at cycle %0d", cyc);
    end
    prev_w <= rf_write | rf_writeu | rf_inc | rf_dec;
    if (done) begin
      if (q.size() == 0) begin
        nerr++; $display("FAIL unexpected_done: done=1 at cycle %0d with no command pending", cyc);
      end else begin
        e = q.pop_front();
        nvec++;
        if (opa !== e.opa || opb !== e.opb || err !== e.err || cyc != e.cyc) begin
          nerr++;
          $display("FAIL completion: opa=%h opb=%h err=%b cyc=%0d, required opa=%h opb=%h err=%b cyc=%0d",
                   opa, opb, err, cyc, e.opa, e.opb, e.err, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    nvec++;
    if (act !== req) begin
      nerr++; $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called and returns at #1 after a posedge. Waits for the sequencer to be
  // able to accept, issues one command, optionally hammers start while busy.
  task automatic issue(input logic [2:0] c, input logic [5:0] s, input logic [5:0] t,
                       input logic [5:0] d, input logic [15:0] w,
                       input logic [15:0] ea, input logic [15:0] eb, input logic e,
                       input int lat, input bit push, input bit junk);
    exp_t x;
    int   n;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    if (busy) begin
      nerr++; $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
    start = 1'b1; cmd = c; rs = s; rt = t; rd = d; wdata = w;
    @(posedge clk); #1;
    if (push) begin
      x.opa = ea; x.opb = eb; x.err = e; x.cyc = cyc + lat - 1;
      q.push_back(x);
    end
    start = 1'b0;
    if (junk) begin
      n = 0;
      while (busy && n < 20) begin
        start = 1'b1; cmd = 3'b010; rs = 6'd7; rt = 6'd7; rd = 6'd5; wdata = 16'hBEEF;
        @(posedge clk); #1; n++;
      end
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_opa", opa, 16'h0);
    check("rst_opb", opb, 16'h0);
    check("rst_flags", {13'h0, done, err, busy}, 16'h0);
    check("rst_id", {10'h0, rf_id}, 16'h0);
    check("rst_din", rf_din, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WRITE then back-to-back FETCH2 of the same id
    issue(3'b010, 6'd0, 6'd0, 6'd5, 16'hA5A5, 16'h0000, 16'h0000, 1'b0, 2, 1, 0);
    issue(3'b001, 6'd5, 6'd5, 6'd0, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0, 3, 1, 0);
    // WRITE, WRITEU merges low byte of wdata into upper byte
    issue(3'b010, 6'd0, 6'd0, 6'd3, 16'h1234, 16'hA5A5, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b011, 6'd0, 6'd0, 6'd3, 16'h00C3, 16'hA5A5, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b000, 6'd3, 6'd9, 6'd0, 16'h0000, 16'hC334, 16'hA5A5, 1'b0, 2, 1, 0);
    // INC/DEC wrap performed by the register file
    issue(3'b010, 6'd0, 6'd0, 6'd7, 16'hFFFF, 16'hC334, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b100, 6'd0, 6'd0, 6'd7, 16'h1111, 16'hC334, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b000, 6'd7, 6'd0, 6'd0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b101, 6'd0, 6'd0, 6'd7, 16'h2222, 16'h0000, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b000, 6'd7, 6'd0, 6'd0, 16'h0000, 16'hFFFF, 16'hA5A5, 1'b0, 2, 1, 0);
    // start held high while busy with a WRITE to id 5: must be ignored
    issue(3'b001, 6'd3, 6'd5, 6'd0, 16'h0000, 16'hC334, 16'hA5A5, 1'b0, 3, 1, 1);
    issue(3'b000, 6'd5, 6'd0, 6'd0, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0, 2, 1, 0);
    // High id bit passes through
    issue(3'b010, 6'd0, 6'd0, 6'h23, 16'h5A5A, 16'hA5A5, 16'hA5A5, 1'b0, 2, 1, 0);
    issue(3'b000, 6'h23, 6'd0, 6'd0, 16'h0000, 16'h5A5A, 16'hA5A5, 1'b0, 2, 1, 0);
    // Illegal commands
    issue(3'b110, 6'd1, 6'd2, 6'd3, 16'h7777, 16'h5A5A, 16'hA5A5, 1'b1, 1, 1, 0);
    issue(3'b111, 6'd1, 6'd2, 6'd3, 16'h7777, 16'h5A5A, 16'hA5A5, 1'b1, 1, 1, 0);

    // Reset during RD_B of a FETCH2: strobes drop in the same cycle, no done
    issue(3'b001, 6'd3, 6'd7, 6'd0, 16'h0000, 16'h0, 16'h0, 1'b0, 3, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_rd_strobe", {11'h0, rf_read, rf_write, rf_writeu, rf_inc, rf_dec}, 16'h0);
    check("rst_rd_id", {10'h0, rf_id}, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_opa", opa, 16'h0);
    check("post_rst_opb", opb, 16'h0);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_done_busy", {14'h0, done, busy}, 16'h0);
      @(posedge clk); #1;
    end
    issue(3'b001, 6'd5, 6'd3, 6'd0, 16'h0000, 16'hA5A5, 16'hC334, 1'b0, 3, 1, 0);

    repeat (6) @(posedge clk);
    #1;
    check("scoreboard_drained", 16'(q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
